// File: rtl/pipe_if_id_skid.sv
// IF/ID pipeline boundary.
//   Forward lane : valid/ready instruction path through a 2-entry skid buffer
//                  (main + skid registers), so in_ready comes from a flop.
//   Backward lane: registered branch/jump redirect from ID back to IF.
//   flush        : synchronous kill of everything held in the forward lane.
//   stall_count  : saturating count of cycles with out_valid & !out_ready.
// Ports:
//   clock, reset (async, active-high)
//   flush
//   in_valid/in_instr/in_ready         IF -> buffer
//   out_valid/out_instr/out_ready      buffer -> ID
//   id_branch_ctrl/value, id_jump_ctrl/value   ID redirect requests
//   if_redirect/_target/_is_jump       registered redirect to IF
//   stall_count                        back-pressure cycle counter
module pipe_if_id_skid #(
   parameter int INSTR_W = 9,
   parameter int ADDR_W  = 8,
   parameter int CNT_W   = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               flush,
   input  logic               in_valid,
   input  logic [INSTR_W-1:0] in_instr,
   output logic               in_ready,
   output logic               out_valid,
   output logic [INSTR_W-1:0] out_instr,
   input  logic               out_ready,
   input  logic               id_branch_ctrl,
   input  logic [ADDR_W-1:0]  id_branch_value,
   input  logic               id_jump_ctrl,
   input  logic [ADDR_W-1:0]  id_jump_value,
   output logic               if_redirect,
   output logic [ADDR_W-1:0]  if_redirect_target,
   output logic               if_redirect_is_jump,
   output logic [CNT_W-1:0]   stall_count
);

   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

   typedef struct packed {
      logic              vld;
      logic [ADDR_W-1:0] target;
      logic              is_jump;
   } redirect_t;

   state_t               state, state_n;
   logic [INSTR_W-1:0]   main_q, main_n;
   logic [INSTR_W-1:0]   skid_q, skid_n;
   redirect_t            redir_q;
   logic                 in_xfer, out_xfer;

   assign in_xfer  = in_valid & in_ready;
   assign out_xfer = out_valid & out_ready;

   // Forward-lane next state. Flush overrides every transition: a beat
   // accepted in the flush cycle is dropped, a beat taken by ID is gone anyway.
   always_comb begin
      state_n = state;
      main_n  = main_q;
      skid_n  = skid_q;
      if (flush) begin
         state_n = EMPTY;
         main_n  = '0;
         skid_n  = '0;
      end else begin
         case (state)
            EMPTY: if (in_xfer) begin
               state_n = ONE;
               main_n  = in_instr;
            end
            ONE: begin
               if (in_xfer && out_xfer) begin
                  main_n = in_instr;
               end else if (in_xfer) begin
                  state_n = TWO;
                  skid_n  = in_instr;
               end else if (out_xfer) begin
                  state_n = EMPTY;
               end
            end
            // in_ready is low here, so only the drain side can move.
            TWO: if (out_xfer) begin
               state_n = ONE;
               main_n  = skid_q;
            end
            default: state_n = EMPTY;
         endcase
      end
   end

   // out_valid and in_ready are decoded from the next state so both are flops.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= EMPTY;
         main_q    <= '0;
         skid_q    <= '0;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         state     <= state_n;
         main_q    <= main_n;
         skid_q    <= skid_n;
         out_valid <= (state_n != EMPTY);
         in_ready  <= (state_n != TWO);
      end
   end

   assign out_instr = main_q;

   // Redirect lane: jump wins over branch; target/is_jump hold when idle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         redir_q <= '0;
      end else begin
         redir_q.vld <= id_jump_ctrl | id_branch_ctrl;
         if (id_jump_ctrl) begin
            redir_q.target  <= id_jump_value;
            redir_q.is_jump <= 1'b1;
         end else if (id_branch_ctrl) begin
            redir_q.target  <= id_branch_value;
            redir_q.is_jump <= 1'b0;
         end
      end
   end

   assign if_redirect         = redir_q.vld;
   assign if_redirect_target  = redir_q.target;
   assign if_redirect_is_jump = redir_q.is_jump;

   // Back-pressure counter, saturating at all-ones. Counts in flush cycles too.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stall_count <= '0;
      end else if (out_valid && !out_ready && (stall_count != {CNT_W{1'b1}})) begin
         stall_count <= stall_count + CNT_W'(1);
      end
   end

endmodule
